// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add/subtract performed one nibble per
// clock on a single 4-bit carry-look-ahead slice, LS nibble first, with the
// inter-nibble carry held in a register. start/busy/done handshake.

// 4-bit carry-look-ahead slice with group propagate/generate outputs.
module cla4_slice (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Ci,
  output logic [3:0] S,
  output logic       Co,
  output logic       PG,
  output logic       GG
);
  logic [3:0] p, g, c;

  // Flat lookahead equations: every carry is a two-level function of p/g/Ci.
  always_comb begin
    p    = A ^ B;
    g    = A & B;
    c[0] = Ci;
    c[1] = g[0] | (p[0] & Ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Ci);
    GG   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    PG   = &p;
    Co   = GG | (PG & Ci);
    S    = p ^ c;
  end
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             OVF
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] op_a, op_b, work, work_nx;
  logic             carry;
  logic [KW-1:0]    k;
  logic             a_msb, b_msb;
  logic             accept, last;

  logic [3:0]       slice_s;
  logic             slice_co, slice_pg, slice_gg;

  // Operands are accepted only when no operation is in flight; DONE counts as
  // free so a held start chains without an idle bubble.
  assign accept = start && (state == ST_IDLE || state == ST_DONE);
  assign last   = (k == K_LAST);

  cla4_slice u_slice (
    .A  (op_a[3:0]),
    .B  (op_b[3:0]),
    .Ci (carry),
    .S  (slice_s),
    .Co (slice_co),
    .PG (slice_pg),
    .GG (slice_gg)
  );

  // New slice sum enters at the top; after NIB steps the LS nibble has
  // shifted all the way down to bits [3:0].
  assign work_nx = (work >> 4) | {slice_s, {(WIDTH-4){1'b0}}};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (last)   state_nx = ST_DONE;
      ST_DONE: state_nx = accept ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath: capture on accept, shift one nibble per RUN cycle, publish the
  // result only on the final nibble so S/Co/OVF hold between operations.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_a  <= '0;
      op_b  <= '0;
      work  <= '0;
      carry <= 1'b0;
      k     <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      S     <= '0;
      Co    <= 1'b0;
      OVF   <= 1'b0;
    end else if (accept) begin
      op_a  <= A;
      op_b  <= sub ? ~B : B;
      carry <= sub ? 1'b1 : Ci;
      k     <= '0;
      a_msb <= A[WIDTH-1];
      b_msb <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
    end else if (state == ST_RUN) begin
      op_a  <= op_a >> 4;
      op_b  <= op_b >> 4;
      carry <= slice_co;
      k     <= k + 1'b1;
      work  <= work_nx;
      if (last) begin
        S   <= work_nx;
        Co  <= slice_co;
        OVF <= (a_msb == b_msb) && (work_nx[WIDTH-1] != a_msb);
      end
    end
  end

  // Group signals are not needed for a single slice; they are kept as a
  // consistency cross-check of the slice's lookahead carry-out.
  always_ff @(posedge clk) begin
    if (rst && state == ST_RUN)
      assert (slice_co == (slice_gg | (slice_pg & carry)));
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16): directed
// cases, protocol cases and randomized operations against an arithmetic model.
module tb_nibble_serial_adder_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, start, sub, Ci;
  logic [WIDTH-1:0] A, B;
  logic             busy, done, Co, OVF;
  logic [WIDTH-1:0] S;

  int n_chk  = 0;
  int n_pass = 0;
  logic [WIDTH+1:0] last_exp = '0;  // {OVF, Co, S}

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B), .Ci(Ci),
    .busy(busy), .done(done), .S(S), .Co(Co), .OVF(OVF)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Full-width arithmetic: result = A + (sub ? -B : B + Ci), returned as {OVF, Co, S}.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, b,
                                            input logic ci, sb);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    logic             ovf;
    bb  = sb ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sb ? 1'b1 : ci);
    ovf = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    return {ovf, sum};
  endfunction

  // Called just after a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic ci, sb, input int poke_at);
    int lat;
    A = a; B = b; Ci = ci; sub = sb; start = 1'b1;
    last_exp = model(a, b, ci, sb);
    @(negedge clk);
    start = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); Ci = 1'($urandom); sub = 1'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    lat = 0;
    while (done !== 1'b1 && lat < 4*NIB + 4) begin
      if (lat > 0) chk("busy_during_run", 32'(busy), 32'd1);
      if (lat == poke_at) begin
        start = 1'b1; A = WIDTH'($urandom); B = WIDTH'($urandom);
        Ci = 1'($urandom); sub = 1'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    chk("latency", 32'(lat), 32'(NIB));
    chk("S", 32'(S), 32'(last_exp[WIDTH-1:0]));
    chk("Co", 32'(Co), 32'(last_exp[WIDTH]));
    chk("OVF", 32'(OVF), 32'(last_exp[WIDTH+1]));
    chk("busy_at_done", 32'(busy), 32'd0);
  endtask

  // One cycle after DONE with no start: done drops, results hold.
  task automatic idle_after;
    @(negedge clk);
    chk("done_falls", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("S_hold", 32'(S), 32'(last_exp[WIDTH-1:0]));
  endtask

  initial begin
    int dcount;
    rst = 1'b0; start = 1'b0; sub = 1'b0; Ci = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Co", 32'(Co), 32'd0);
    chk("rst_OVF", 32'(OVF), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    run_op(16'h1234, 16'h0FED, 1'b0, 1'b0, -1); idle_after();
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, -1); idle_after();
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, -1); idle_after();
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, -1); idle_after();
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, -1); idle_after();

    // start re-pulsed two cycles into RUN is ignored.
    run_op(16'h4321, 16'h1111, 1'b0, 1'b0, 2); idle_after();

    // start held through DONE: second op accepted with no bubble.
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, -1);
    run_op(16'h0100, 16'h0200, 1'b0, 1'b1, -1);
    idle_after();

    // Reset mid-RUN, with start also asserted at the reset edge.
    A = 16'h1357; B = 16'h2468; Ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    rst = 1'b0; start = 1'b1; A = 16'hFFFF; B = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_S", 32'(S), 32'd0);
    chk("midrst_Co", 32'(Co), 32'd0);
    chk("midrst_OVF", 32'(OVF), 32'd0);
    rst = 1'b1;
    dcount = 0;
    repeat (2*NIB) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("no_done_after_abort", 32'(dcount), 32'd0);
    last_exp = '0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, -1); idle_after();

    // Randomized operations, sometimes chained back to back.
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NIB-1)) : -1);
      if ($urandom_range(0, 2) != 0) idle_after();
    end
    if (done === 1'b1) idle_after();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Sequencer that computes a WIDTH-bit add or subtract on a single 4-bit carry-look-ahead slice (ports A, B, Ci → S, Co, PG, GG). It processes one nibble per clock, least significant nibble first, and chains the carry through a register. Results are presented under a start/busy/done handshake. It is the area-reduced alternative to a full-width hierarchical CLA and serves as the multi-cycle adder for narrow-datapath users.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8; NIB = WIDTH/4
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- start  input  1  request pulse; sampled only when not busy
- sub  input  1  0 = A+B+Ci, 1 = A−B (Ci ignored)
- A  input  WIDTH  operand A, sampled with start
- B  input  WIDTH  operand B, sampled with start
- Ci  input  1  carry-in for add, sampled with start
- busy  output  1  high while nibbles are being processed
- done  output  1  one-cycle pulse when S/Co/OVF update
- S  output  WIDTH  result, registered
- Co  output  1  carry-out of MSB nibble (for sub: 1 = no borrow)
- OVF  output  1  two's-complement overflow

## Operation
- One slice instance; PG/GG unused by this block.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle; returns to IDLE unless start is accepted.
- Accept (state IDLE or DONE, start=1):
  - opA ← A
  - opB ← sub ? ~B : B
  - carry ← sub ? 1 : Ci
  - nibble count k ← 0
  - a_msb ← A[WIDTH-1]
  - b_msb ← effective opB[WIDTH-1]
  - state → RUN
- RUN, each edge:
  - slice inputs are opA[3:0], opB[3:0], carry.
  - slice S is shifted into the top of the work register (work ← {S_slice, work[WIDTH-1:4]}).
  - opA and opB shift right by 4; carry ← slice Co; k ← k+1.
- Completion, on the edge where k = NIB−1:
  - S ← final work value.
  - Co ← slice Co.
  - OVF ← (a_msb == b_msb) && (result MSB != a_msb).
  - state → DONE.
- S, Co and OVF change only on completion edges. Between completions they hold their previous values.
- start while busy=1 is ignored and not queued.
- Width rule: carry between nibbles is exactly 1 bit. The final carry is not folded back into S.

## Timing
- Reset (rst=0 at an edge), regardless of state: state=IDLE, busy=0, done=0, S=0, Co=0, OVF=0, k=0, work/op registers=0.
- An operation in progress at reset is aborted and no done is issued.
- Start accepted at edge E0:
  - busy=1 from E0 to E(NIB).
  - S/Co/OVF valid and done=1 from E(NIB) to E(NIB+1).
  - Latency: NIB cycles from the accepting edge (4 for WIDTH=16).
- Back-to-back: start=1 during the DONE cycle is accepted at E(NIB+1). busy rises again that edge while done falls; there is no idle bubble. Throughput is one result per NIB+1 cycles.
- start and rst both asserted: reset wins.
- A, B, Ci and sub may change freely after the accepting edge; captured copies are used.

## Test plan
- WIDTH=16, A=0x1234, B=0x0FED, Ci=0, sub=0, start pulse → busy for 4 cycles; done pulse 4 cycles after accept; S=0x2221, Co=0, OVF=0.
- A=0xFFFF, B=0x0001, Ci=0, sub=0 → S=0x0000, Co=1, OVF=0; carry propagates through all 4 nibbles.
- A=0x7FFF, B=0x0000, Ci=1, sub=0 → S=0x8000, Co=0, OVF=1.
- A=0x0005, B=0x0007, sub=1, Ci=1 (ignored) → S=0xFFFE, Co=0, OVF=0; then A=0x8000, B=0x0001, sub=1 → S=0x7FFF, Co=1, OVF=1.
- Protocol:
  - start re-pulsed with different operands 2 cycles into RUN → ignored; first result unchanged.
  - start held through DONE → second operation accepted with no idle cycle; result correct.
- Reset mid-RUN (rst=0 at cycle 2 after accept) → next cycle busy=0, done=0, S=0, Co=0, OVF=0; no done pulse follows; a new start then completes normally.
